// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing one L2 port between the instruction and data L1s.
// The granted request is captured and replayed to L2 until L2_resp. A single RELEASE cycle follows before re-arbitration.
module l2_request_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_read,
  input  logic                  instr_write,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [LINE_WIDTH-1:0] instr_wdata,
  output logic [LINE_WIDTH-1:0] instr_rdata,
  output logic                  instr_resp,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [LINE_WIDTH-1:0] data_wdata,
  output logic [LINE_WIDTH-1:0] data_rdata,
  output logic                  data_resp,
  output logic                  L2_read,
  output logic                  L2_write,
  output logic [ADDR_WIDTH-1:0] L2_addr,
  output logic [LINE_WIDTH-1:0] L2_wdata,
  input  logic [LINE_WIDTH-1:0] L2_rdata,
  input  logic                  L2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                state_r, next_state_s;
  logic                  last_grant_r, next_last_grant_s;
  logic                  cap_read_r, cap_write_r;
  logic [ADDR_WIDTH-1:0] cap_addr_r;
  logic [LINE_WIDTH-1:0] cap_wdata_r;

  logic                  req_i_s, req_d_s;
  logic                  load_s, sel_data_s;
  logic                  sel_read_s, sel_write_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [LINE_WIDTH-1:0] sel_wdata_s;
  logic                  serving_s;

  assign req_i_s = instr_read | instr_write;
  assign req_d_s = data_read | data_write;

  // Arbitration in IDLE and transaction sequencing; last_grant only moves on completion.
  always_comb begin
    next_state_s      = state_r;
    next_last_grant_s = last_grant_r;
    load_s            = 1'b0;
    sel_data_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i_s && req_d_s) begin
          load_s     = 1'b1;
          sel_data_s = ~last_grant_r;
        end else if (req_i_s) begin
          load_s     = 1'b1;
          sel_data_s = 1'b0;
        end else if (req_d_s) begin
          load_s     = 1'b1;
          sel_data_s = 1'b1;
        end else begin
          load_s     = 1'b0;
          sel_data_s = 1'b0;
        end
        if (load_s) begin
          next_state_s = sel_data_s ? SERVE_D : SERVE_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      SERVE_I: begin
        if (L2_resp) begin
          next_state_s      = RELEASE;
          next_last_grant_s = 1'b0;
        end else begin
          next_state_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (L2_resp) begin
          next_state_s      = RELEASE;
          next_last_grant_s = 1'b1;
        end else begin
          next_state_s = SERVE_D;
        end
      end
      RELEASE: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Select the granted port's request fields for capture.
  always_comb begin
    if (sel_data_s) begin
      sel_read_s  = data_read;
      sel_write_s = data_write;
      sel_addr_s  = data_addr;
      sel_wdata_s = data_wdata;
    end else begin
      sel_read_s  = instr_read;
      sel_write_s = instr_write;
      sel_addr_s  = instr_addr;
      sel_wdata_s = instr_wdata;
    end
  end

  // State, round-robin pointer and capture registers; write wins over read on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cap_read_r   <= 1'b0;
      cap_write_r  <= 1'b0;
      cap_addr_r   <= {ADDR_WIDTH{1'b0}};
      cap_wdata_r  <= {LINE_WIDTH{1'b0}};
    end else begin
      state_r      <= next_state_s;
      last_grant_r <= next_last_grant_s;
      if (load_s) begin
        cap_write_r <= sel_write_s;
        cap_read_r  <= sel_read_s & ~sel_write_s;
        cap_addr_r  <= sel_addr_s;
        cap_wdata_r <= sel_wdata_s;
      end
    end
  end

  assign serving_s   = (state_r == SERVE_I) || (state_r == SERVE_D);
  assign L2_read     = serving_s & cap_read_r;
  assign L2_write    = serving_s & cap_write_r;
  assign L2_addr     = cap_addr_r;
  assign L2_wdata    = cap_wdata_r;

  // Completion is combinational from L2_resp but suppressed while reset is asserted.
  assign instr_resp  = ~reset & (state_r == SERVE_I) & L2_resp;
  assign data_resp   = ~reset & (state_r == SERVE_D) & L2_resp;
  assign instr_rdata = L2_rdata;
  assign data_rdata  = L2_rdata;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever a resp appears.
module tb_l2_request_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_read, instr_write, data_read, data_write;
  logic [AW-1:0] instr_addr, data_addr, L2_addr;
  logic [LW-1:0] instr_wdata, data_wdata, instr_rdata, data_rdata, L2_wdata, L2_rdata;
  logic          instr_resp, data_resp, L2_read, L2_write, L2_resp;

  always #5 clk = ~clk;

  l2_request_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_write(instr_write), .instr_addr(instr_addr),
    .instr_wdata(instr_wdata), .instr_rdata(instr_rdata), .instr_resp(instr_resp),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_resp(data_resp),
    .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
    .L2_rdata(L2_rdata), .L2_resp(L2_resp)
  );

  typedef struct packed {
    logic          port;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic port, input logic [AW-1:0] addr, input logic rd,
                              input logic wr, input logic [LW-1:0] wd, input logic [LW-1:0] rdt);
    exp_t e;
    e.port = port; e.addr = addr; e.rd = rd; e.wr = wr; e.wdata = wd; e.rdata = rdt;
    return e;
  endfunction

  // Scoreboard monitor: every resp pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (instr_resp === 1'b1 || data_resp === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp actual instr=%b data=%b required=none", instr_resp, data_resp);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", LW'(data_resp), LW'(e.port));
        check("resp_onehot", LW'(instr_resp & data_resp), {LW{1'b0}});
        check("resp_addr", LW'(L2_addr), LW'(e.addr));
        check("resp_l2_read", LW'(L2_read), LW'(e.rd));
        check("resp_l2_write", LW'(L2_write), LW'(e.wr));
        if (e.wr) check("resp_wdata", L2_wdata, e.wdata);
        check("resp_rdata", e.port ? data_rdata : instr_rdata, e.rdata);
      end
    end
  end

  task automatic clear_inputs();
    instr_read = 1'b0; instr_write = 1'b0; instr_addr = '0; instr_wdata = '0;
    data_read  = 1'b0; data_write  = 1'b0; data_addr  = '0; data_wdata  = '0;
    L2_resp = 1'b0; L2_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    @(negedge clk);
    check("rst_l2_read", LW'(L2_read), {LW{1'b0}});
    check("rst_l2_write", LW'(L2_write), {LW{1'b0}});
    check("rst_l2_addr", LW'(L2_addr), {LW{1'b0}});
    check("rst_resp", LW'({instr_resp, data_resp}), {LW{1'b0}});
    tick();
    reset = 1'b0;
  endtask

  // Wait for the strobe, check it is held, pulse L2_resp, then check the release/idle gap.
  task automatic serve(input exp_t e, input int exp_lat, input int hold, input bit mutate,
                       input logic [1:0] drop);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (L2_read || L2_write) seen = 1'b1;
      else begin
        n++;
        tick();
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL strobe_timeout actual=none required=strobe addr=%0h", e.addr);
      return;
    end
    check("grant_latency", LW'(n), LW'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_read", LW'(L2_read), LW'(e.rd));
      check("hold_write", LW'(L2_write), LW'(e.wr));
      check("hold_addr", LW'(L2_addr), LW'(e.addr));
      if (e.wr) check("hold_wdata", L2_wdata, e.wdata);
      tick();
      if (mutate && k == 0) begin
        data_addr  = 16'h3000;
        data_write = 1'b0;
      end
    end
    L2_resp  = 1'b1;
    L2_rdata = e.rdata;
    @(negedge clk);
    check("respcyc_strobe", LW'({L2_read, L2_write}), LW'({e.rd, e.wr}));
    tick();
    L2_rdata = {LW{1'b1}};
    if (drop[0]) begin instr_read = 1'b0; instr_write = 1'b0; end
    if (drop[1]) begin data_read = 1'b0; data_write = 1'b0; end
    @(negedge clk);
    check("release_strobe", LW'({L2_read, L2_write}), {LW{1'b0}});
    check("release_stray_resp", LW'({instr_resp, data_resp}), {LW{1'b0}});
    tick();
    L2_resp = 1'b0;
    @(negedge clk);
    check("idle_strobe", LW'({L2_read, L2_write}), {LW{1'b0}});
    tick();
  endtask

  initial begin
    exp_t ei, ed, e1, e2, e3, e4;
    reset = 1'b1;
    clear_inputs();
    do_reset();

    // Single instruction read.
    instr_read = 1'b1; instr_addr = 16'h1240;
    ei = mk(1'b0, 16'h1240, 1'b1, 1'b0, '0, {16{8'hAB}});
    exp_q.push_back(ei);
    serve(ei, 1, 2, 1'b0, 2'b01);

    // Simultaneous requests after reset: instr first, then data write.
    do_reset();
    instr_read = 1'b1; instr_addr = 16'h0100;
    data_write = 1'b1; data_addr = 16'h8000; data_wdata = {4{32'hDEADBEEF}};
    ei = mk(1'b0, 16'h0100, 1'b1, 1'b0, '0, {4{32'h11111111}});
    ed = mk(1'b1, 16'h8000, 1'b0, 1'b1, {4{32'hDEADBEEF}}, {4{32'h22222222}});
    exp_q.push_back(ei); exp_q.push_back(ed);
    serve(ei, 1, 1, 1'b0, 2'b01);
    serve(ed, 0, 1, 1'b0, 2'b10);

    // Continuous requests alternate I, D, I, D.
    instr_read = 1'b1; instr_addr = 16'h0200;
    data_read  = 1'b1; data_addr  = 16'h0300;
    e1 = mk(1'b0, 16'h0200, 1'b1, 1'b0, '0, {4{32'hA0000001}});
    e2 = mk(1'b1, 16'h0300, 1'b1, 1'b0, '0, {4{32'hB0000002}});
    e3 = mk(1'b0, 16'h0200, 1'b1, 1'b0, '0, {4{32'hA0000003}});
    e4 = mk(1'b1, 16'h0300, 1'b1, 1'b0, '0, {4{32'hB0000004}});
    exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3); exp_q.push_back(e4);
    serve(e1, 1, 1, 1'b0, 2'b00);
    serve(e2, 0, 1, 1'b0, 2'b00);
    serve(e3, 0, 1, 1'b0, 2'b00);
    serve(e4, 0, 1, 1'b0, 2'b11);

    // Data L1 changes its request mid-service; captured values must hold.
    data_write = 1'b1; data_addr = 16'h2000; data_wdata = {8{16'h5A5A}};
    ed = mk(1'b1, 16'h2000, 1'b0, 1'b1, {8{16'h5A5A}}, {4{32'hC0FFEE00}});
    exp_q.push_back(ed);
    serve(ed, 1, 3, 1'b1, 2'b10);

    // Read and write together: write takes precedence.
    data_read = 1'b1; data_write = 1'b1; data_addr = 16'h4000; data_wdata = {4{32'h01234567}};
    ed = mk(1'b1, 16'h4000, 1'b0, 1'b1, {4{32'h01234567}}, {4{32'h76543210}});
    exp_q.push_back(ed);
    serve(ed, 1, 2, 1'b0, 2'b10);

    // Instruction write so the pointer favours data before the reset test.
    instr_write = 1'b1; instr_addr = 16'h0A00; instr_wdata = {4{32'hFACEFACE}};
    ei = mk(1'b0, 16'h0A00, 1'b0, 1'b1, {4{32'hFACEFACE}}, {4{32'h33333333}});
    exp_q.push_back(ei);
    serve(ei, 1, 1, 1'b0, 2'b01);

    // Reset in SERVE_D coinciding with L2_resp, then a late L2_resp in IDLE.
    data_read = 1'b1; data_addr = 16'h5000;
    tick();
    @(negedge clk);
    check("pre_reset_strobe", LW'(L2_read), LW'(1'b1));
    tick();
    reset = 1'b1; L2_resp = 1'b1; L2_rdata = {4{32'h44444444}};
    @(negedge clk);
    check("reset_resp_gate", LW'(data_resp), {LW{1'b0}});
    tick();
    reset = 1'b0; data_read = 1'b0;
    @(negedge clk);
    check("post_reset_strobe", LW'({L2_read, L2_write}), {LW{1'b0}});
    check("post_reset_resp", LW'({instr_resp, data_resp}), {LW{1'b0}});
    tick();
    L2_resp = 1'b0;
    @(negedge clk);
    check("late_resp_idle", LW'({L2_read, L2_write}), {LW{1'b0}});
    tick();

    // First tie after reset goes to instr.
    instr_read = 1'b1; instr_addr = 16'h0600;
    data_read  = 1'b1; data_addr  = 16'h0700;
    ei = mk(1'b0, 16'h0600, 1'b1, 1'b0, '0, {4{32'h55555555}});
    ed = mk(1'b1, 16'h0700, 1'b1, 1'b0, '0, {4{32'h66666666}});
    exp_q.push_back(ei); exp_q.push_back(ed);
    serve(ei, 1, 1, 1'b0, 2'b01);
    serve(ed, 0, 1, 1'b0, 2'b10);

    repeat (3) tick();
    check("queue_drained", LW'(exp_q.size()), {LW{1'b0}});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
